// File: rtl/ysyx_23060208_axi_pkg.sv
// Shared AXI-Lite read-path definitions: crossbar FSM states, response codes
// and the CLINT address window (also used by ysyx_23060208_clint).
package ysyx_23060208_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } xbar_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Base must stay below 2^32-8 so base+size never wraps.
  localparam logic [31:0] CLINT_BASE = 32'ha000_0048;
  localparam logic [31:0] CLINT_SIZE = 32'd8;

endpackage

// File: rtl/ysyx_23060208_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//  req  : request vector, bit i = master i
//  last : index of the master granted most recently
//  gnt  : one-hot grant (0 when nobody requests)
// The last-grant history lives in the caller.
module ysyx_23060208_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // Contention: hand the grant to whoever did not win last time.
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ysyx_23060208_rd_xbar.sv
// 2x2 AXI-Lite read crossbar: IFU (M0) and LSU (M1) onto SRAM (S0) and
// CLINT (S1). Round-robin arbitration, address decode on the latched
// address, one outstanding read end-to-end.
//  clk, rst           : clock, synchronous active-high reset
//  m{0,1}_ar*/r*      : master-side AR/R channels (xbar is the slave)
//  s{0,1}_ar*/r*      : slave-side AR/R channels (xbar is the master)
module ysyx_23060208_rd_xbar #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = ysyx_23060208_axi_pkg::CLINT_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] s0_araddr,
  output logic                  s0_arvalid,
  input  logic                  s0_arready,
  input  logic [DATA_WIDTH-1:0] s0_rdata,
  input  logic [1:0]            s0_rresp,
  input  logic                  s0_rvalid,
  output logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s1_araddr,
  output logic                  s1_arvalid,
  input  logic                  s1_arready,
  input  logic [DATA_WIDTH-1:0] s1_rdata,
  input  logic [1:0]            s1_rresp,
  input  logic                  s1_rvalid,
  output logic                  s1_rready
);
  import ysyx_23060208_axi_pkg::*;

  localparam logic [DATA_WIDTH-1:0] CLINT_END = CLINT_BASE + DATA_WIDTH'(CLINT_SIZE);

  // Bundle per-port signals so the datapath can be indexed by grant/select.
  logic [1:0][DATA_WIDTH-1:0] m_araddr, m_rdata, s_araddr, s_rdata;
  logic [1:0][1:0]            m_rresp, s_rresp;
  logic [1:0]                 m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]                 s_arvalid, s_arready, s_rvalid, s_rready;

  assign m_araddr  = {m1_araddr, m0_araddr};
  assign m_arvalid = {m1_arvalid, m0_arvalid};
  assign m_rready  = {m1_rready, m0_rready};
  assign s_arready = {s1_arready, s0_arready};
  assign s_rdata   = {s1_rdata, s0_rdata};
  assign s_rresp   = {s1_rresp, s0_rresp};
  assign s_rvalid  = {s1_rvalid, s0_rvalid};

  assign {m1_arready, m0_arready} = m_arready;
  assign {m1_rvalid, m0_rvalid}   = m_rvalid;
  assign {m1_rdata, m0_rdata}     = m_rdata;
  assign {m1_rresp, m0_rresp}     = m_rresp;
  assign {s1_arvalid, s0_arvalid} = s_arvalid;
  assign {s1_araddr, s0_araddr}   = s_araddr;
  assign {s1_rready, s0_rready}   = s_rready;

  xbar_state_e           state_q, state_d;
  logic                  last_q;   // master granted by the previous transaction
  logic                  g_q;      // master owning the current transaction
  logic                  sel_q;    // 1 = CLINT, 0 = SRAM
  logic [DATA_WIDTH-1:0] addr_q;

  logic [1:0]            gnt;
  logic                  gidx, win_hit, r_done;

  ysyx_23060208_rr_arb2 u_arb (
    .req  (m_arvalid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign gidx    = gnt[1];
  assign win_hit = (m_araddr[gidx] >= CLINT_BASE) && (m_araddr[gidx] < CLINT_END);
  assign r_done  = s_rvalid[sel_q] && m_rready[g_q];

  always_comb begin
    state_d   = state_q;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_arvalid = '0;
    s_araddr  = '0;
    s_rready  = '0;
    case (state_q)
      IDLE: begin
        // Gate with rst so no handshake is signalled while reset is held.
        if (|m_arvalid && !rst) begin
          m_arready = gnt;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        s_arvalid[sel_q] = 1'b1;
        s_araddr[sel_q]  = addr_q;
        if (s_arready[sel_q]) state_d = DATA;
      end
      DATA: begin
        m_rvalid[g_q]   = s_rvalid[sel_q];
        m_rdata[g_q]    = s_rdata[sel_q];
        m_rresp[g_q]    = s_rresp[sel_q];
        s_rready[sel_q] = m_rready[g_q];
        if (r_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      g_q     <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |m_arvalid) begin
        g_q    <= gidx;
        sel_q  <= win_hit;
        addr_q <= m_araddr[gidx];
      end
      if (state_q == DATA && r_done) last_q <= g_q;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_xbar.sv
module tb_ysyx_23060208_rd_xbar;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][31:0] m_araddr, m_rdata, s_araddr, s_rdata;
  logic [1:0][1:0]  m_rresp, s_rresp;
  logic [1:0]       m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]       s_arvalid, s_arready, s_rvalid, s_rready;

  ysyx_23060208_rd_xbar dut (
    .clk        (clk),
    .rst        (rst),
    .m0_araddr  (m_araddr[0]),  .m0_arvalid (m_arvalid[0]), .m0_arready (m_arready[0]),
    .m0_rdata   (m_rdata[0]),   .m0_rresp   (m_rresp[0]),   .m0_rvalid  (m_rvalid[0]),
    .m0_rready  (m_rready[0]),
    .m1_araddr  (m_araddr[1]),  .m1_arvalid (m_arvalid[1]), .m1_arready (m_arready[1]),
    .m1_rdata   (m_rdata[1]),   .m1_rresp   (m_rresp[1]),   .m1_rvalid  (m_rvalid[1]),
    .m1_rready  (m_rready[1]),
    .s0_araddr  (s_araddr[0]),  .s0_arvalid (s_arvalid[0]), .s0_arready (s_arready[0]),
    .s0_rdata   (s_rdata[0]),   .s0_rresp   (s_rresp[0]),   .s0_rvalid  (s_rvalid[0]),
    .s0_rready  (s_rready[0]),
    .s1_araddr  (s_araddr[1]),  .s1_arvalid (s_arvalid[1]), .s1_arready (s_arready[1]),
    .s1_rdata   (s_rdata[1]),   .s1_rresp   (s_rresp[1]),   .s1_rvalid  (s_rvalid[1]),
    .s1_rready  (s_rready[1])
  );

  int cmps = 0;
  int errs = 0;
  int exp_last;  // reference model: who won the last completed read

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int is_clint(input logic [31:0] a);
    return ((a >= 32'ha000_0048) && (a < 32'ha000_0048 + 32'd8)) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0; m_araddr = '0; m_rready = '0;
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0;
  endtask

  // One complete read. ar_wait: slave AR stall cycles; r_wait: cycles before
  // slave rvalid; rr_wait: cycles master holds rready low once data is valid.
  task automatic txn(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                     input int ar_wait, input int r_wait, input int rr_wait,
                     input logic [31:0] d, input logic [1:0] rsp);
    int g, o, s, os, last_k;
    logic [31:0] ea;
    bit sv;
    if (r0 && r1) g = (exp_last == 1) ? 0 : 1;
    else          g = r0 ? 0 : 1;
    o  = 1 - g;
    ea = (g == 1) ? a1 : a0;
    s  = is_clint(ea);
    os = 1 - s;

    // Request cycle: slave-side noise must be ignored.
    m_arvalid = {r1, r0};
    m_araddr[0] = a0; m_araddr[1] = a1;
    m_rready = '0;
    s_arready = 2'($urandom); s_rvalid = 2'($urandom);
    #1;
    chk("idle_arready_grant", m_arready[g], 1'b1);
    chk("idle_arready_other", m_arready[o], 1'b0);
    chk("idle_s_arvalid", s_arvalid, 2'b00);
    chk("idle_m_rvalid", m_rvalid, 2'b00);
    step();
    // Granted master moves on; its address bus may now carry anything.
    m_arvalid[g] = 1'b0;
    m_araddr[g]  = $urandom;

    for (int k = 0; k <= ar_wait; k++) begin
      s_arready[s]  = (k == ar_wait);
      s_arready[os] = 1'($urandom);
      s_rvalid      = 2'($urandom);
      s_rdata       = {$urandom, $urandom};
      #1;
      chk("addr_s_arvalid_sel", s_arvalid[s], 1'b1);
      chk("addr_s_arvalid_oth", s_arvalid[os], 1'b0);
      chk("addr_s_araddr_sel", s_araddr[s], ea);
      chk("addr_s_araddr_oth", s_araddr[os], 32'h0);
      chk("addr_m_arready", m_arready, 2'b00);
      chk("addr_m_rvalid", m_rvalid, 2'b00);
      step();
    end

    s_arready = '0;
    last_k = r_wait + rr_wait;
    for (int k = 0; k <= last_k; k++) begin
      sv = (k >= r_wait);
      s_rvalid[s]  = sv;
      s_rdata[s]   = d;
      s_rresp[s]   = rsp;
      s_rvalid[os] = 1'($urandom);
      s_rdata[os]  = $urandom;
      s_rresp[os]  = 2'($urandom);
      m_rready[g]  = sv ? (k == last_k) : 1'($urandom);
      m_rready[o]  = 1'($urandom);
      #1;
      chk("data_m_rvalid_g", m_rvalid[g], sv);
      chk("data_m_rvalid_o", m_rvalid[o], 1'b0);
      chk("data_m_rdata_g", m_rdata[g], d);
      chk("data_m_rresp_g", m_rresp[g], rsp);
      chk("data_m_rdata_o", m_rdata[o], 32'h0);
      chk("data_m_rresp_o", m_rresp[o], 2'b00);
      chk("data_s_rready_sel", s_rready[s], m_rready[g]);
      chk("data_s_rready_oth", s_rready[os], 1'b0);
      chk("data_s_arvalid", s_arvalid, 2'b00);
      chk("data_m_arready", m_arready, 2'b00);
      step();
    end
    s_rvalid = '0; m_rready = '0;
    exp_last = g;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step(); step();
    exp_last = 1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();
    // Reset outputs, including a request held during reset.
    m_arvalid = 2'b11;
    s_rvalid  = 2'b11;
    #1;
    chk("rst_m_arready", m_arready, 2'b00);
    chk("rst_m_rvalid", m_rvalid, 2'b00);
    chk("rst_s_arvalid", s_arvalid, 2'b00);
    chk("rst_s_rready", s_rready, 2'b00);
    chk("rst_s_araddr0", s_araddr[0], 32'h0);
    chk("rst_s_araddr1", s_araddr[1], 32'h0);
    chk("rst_m_rdata0", m_rdata[0], 32'h0);
    chk("rst_m_rdata1", m_rdata[1], 32'h0);
    chk("rst_m_rresp", {m_rresp[1], m_rresp[0]}, 4'h0);
    step();
    clear_inputs();
    rst = 1'b0;

    // Both request from reset: M0, M1, M0.
    txn(1, 1, 32'h8000_0000, 32'h8000_0004, 0, 0, 0, 32'haaaa_0001, 2'b00);
    txn(1, 1, 32'h8000_0008, 32'ha000_0048, 0, 0, 0, 32'hbbbb_0002, 2'b00);
    txn(1, 1, 32'h8000_000c, 32'h8000_0014, 0, 0, 0, 32'hcccc_0003, 2'b01);

    txn(1, 0, 32'h8000_0010, 32'h0, 0, 0, 0, 32'h1234_5678, 2'b00);
    txn(0, 1, 32'h0, 32'ha000_004c, 0, 0, 0, 32'h0000_0001, 2'b00);
    txn(1, 0, 32'h8000_0100, 32'h0, 5, 0, 3, 32'hdead_beef, 2'b10);

    // Window boundaries.
    txn(0, 1, 32'h0, 32'ha000_0047, 1, 1, 0, 32'h0000_0047, 2'b00);
    txn(1, 0, 32'ha000_0050, 32'h0, 0, 2, 1, 32'h0000_0050, 2'b00);
    txn(0, 1, 32'h0, 32'ha000_0048, 0, 0, 0, 32'h0000_0048, 2'b00);
    txn(1, 0, 32'ha000_004f, 32'h0, 0, 0, 0, 32'h0000_004f, 2'b11);

    // Reset while data is pending: everything drops, nothing delivered.
    m_arvalid = 2'b01; m_araddr[0] = 32'h8000_0040;
    step();
    m_arvalid = 2'b00;
    s_arready[0] = 1'b1;
    step();
    s_arready = '0;
    s_rvalid[0] = 1'b1; s_rdata[0] = 32'h5555_aaaa;
    #1;
    chk("pre_rst_m0_rvalid", m_rvalid[0], 1'b1);
    rst = 1'b1;
    step();
    chk("mid_rst_m_rvalid", m_rvalid, 2'b00);
    chk("mid_rst_s_arvalid", s_arvalid, 2'b00);
    chk("mid_rst_s_rready", s_rready, 2'b00);
    rst = 1'b0;
    clear_inputs();
    exp_last = 1;
    txn(1, 1, 32'ha000_004a, 32'h8000_0020, 1, 1, 1, 32'h7777_0000, 2'b00);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      bit r0, r1;
      logic [31:0] a0, a1;
      int pick;
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      pick = $urandom_range(0, 3);
      a0 = (pick == 0) ? 32'ha000_0048 + $urandom_range(0, 7) :
           (pick == 1) ? 32'ha000_0040 + $urandom_range(0, 31) : $urandom;
      pick = $urandom_range(0, 3);
      a1 = (pick == 0) ? 32'ha000_0048 + $urandom_range(0, 7) :
           (pick == 1) ? 32'ha000_0040 + $urandom_range(0, 31) : $urandom;
      txn(r0, r1, a0, a1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom, 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
